// File: rtl/bool_sweep_ctrl.sv
// bool_sweep_ctrl: sweeps abcd through all 16 vectors, tabulating and counting five boolean functions
module bool_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] rd_addr,
  output logic [3:0] abcd,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [4:0] rd_data,
  output logic [4:0] cnt1,
  output logic [4:0] cnt2,
  output logic [4:0] cnt3,
  output logic [4:0] cnt4,
  output logic [4:0] cnt5
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  state_t     state, state_nx;
  logic [3:0] settle;
  logic [4:0] tbl [16];
  logic [4:0] cnt [5];
  logic [4:0] y;
  logic       a, b, c, d;
  assign {a, b, c, d} = abcd;
  assign y = {~((a | b) ^ (c & ~d)),
              (a & (~b | c)) ^ (d & (b | ~c)),
              (a & b) | (b & c) | (a & c),
              ~((a & b) | (c & ~d)),
              (a ^ b) & (c | ~d)};
  assign busy    = (state == DRIVE) || (state == SAMPLE);
  assign done    = state == DONE;
  assign rd_data = tbl[rd_addr];
  assign cnt1    = cnt[0];
  assign cnt2    = cnt[1];
  assign cnt3    = cnt[2];
  assign cnt4    = cnt[3];
  assign cnt5    = cnt[4];
  // next state: start only matters in IDLE, abort only cancels a running sweep
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? DRIVE : IDLE;
      DRIVE:   state_nx = abort ? IDLE : (settle == SETTLE_LAST) ? SAMPLE : DRIVE;
      SAMPLE:  state_nx = abort ? IDLE : (abcd == 4'hf) ? DONE : DRIVE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  // vector, settle timer, result table, counters and abort flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abcd    <= '0;
      settle  <= '0;
      aborted <= 1'b0;
      for (int i = 0; i < 16; i++) tbl[i] <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          abcd    <= '0;
          settle  <= '0;
          aborted <= 1'b0;
          for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end
        DRIVE: if (abort) aborted <= 1'b1;
          else settle <= settle + 4'd1;
        SAMPLE: if (abort) aborted <= 1'b1;
          else begin
            tbl[abcd] <= y;
            for (int i = 0; i < 5; i++) cnt[i] <= cnt[i] + 5'(y[i]);
            if (abcd != 4'hf) begin
              abcd   <= abcd + 4'd1;
              settle <= '0;
            end
          end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/bool_sweep_ctrl.md
BOOL_SWEEP_CTRL -- requirements
Module: bool_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, range 1..15: cycles each input vector is held before sampling.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begin a sweep; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous cancel of a running sweep.
REQ-006 SHALL have port abcd  output  4  registered test vector: A=abcd[3], B=abcd[2], C=abcd[1], D=abcd[0].
REQ-007 SHALL have port busy  output  1  high while in DRIVE or SAMPLE.
REQ-008 SHALL have port done  output  1  single-cycle pulse when a sweep completes.
REQ-009 SHALL have port aborted  output  1  sticky flag: the last sweep was cancelled.
REQ-010 SHALL have port rd_addr  input  4  result-table read index.
REQ-011 SHALL have port rd_data  output  5  combinational read of table[rd_addr], bit0=Y1 ... bit4=Y5.
REQ-012 SHALL have ports cnt1..cnt5  output  5 each  count of vectors for which Y1..Y5 = 1.

Function
REQ-013 SHALL evaluate internally: Y1=(A^B)&(C|~D); Y2=~((A&B)|(C&~D)); Y3=AB|BC|AC; Y4=(A&(~B|C))^(D&(B|~C)); Y5=~((A|B)^(C&~D)).
REQ-014 SHALL implement the states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 IDLE: on start=1, SHALL clear cnt1..cnt5 and aborted, set abcd=0 and the settle counter=0, and go to DRIVE.
REQ-016 DRIVE: SHALL hold abcd, increment the settle counter, and go to SAMPLE after SETTLE_CYCLES cycles in DRIVE.
REQ-017 SAMPLE (one cycle): SHALL write {Y5..Y1} of the current abcd to table[abcd] and add each Yi to cnti.
REQ-018 SAMPLE, then: if abcd==15, SHALL go to DONE; otherwise SHALL increment abcd, clear the settle counter, and go to DRIVE.
REQ-019 DONE: SHALL assert done for exactly one cycle and then return to IDLE; abcd SHALL stay 15.
REQ-020 Per-vector cost is SETTLE_CYCLES+1 cycles; done SHALL assert exactly 16*(SETTLE_CYCLES+1)+1 cycles after the start edge.
REQ-021 start SHALL be ignored outside IDLE; start held high in IDLE SHALL launch a new sweep immediately after DONE.
REQ-022 abort=1 in DRIVE or SAMPLE SHALL go to IDLE on the next edge.
REQ-023 On abort: aborted SHALL be set, done SHALL NOT pulse, and table/counts SHALL keep their partial contents.
REQ-024 abort and start asserted together in IDLE: start wins and aborted is cleared.
REQ-025 abort SHALL have no effect in IDLE or DONE.
REQ-026 Counters SHALL saturate at 16 by construction (5 bits); no wrap-around is permitted.
REQ-027 Reads SHALL be permitted at any time; an entry not yet written in the current sweep returns its previous value.

Reset
REQ-028 rst=1 SHALL immediately force IDLE and set abcd=0, busy=0, done=0, aborted=0, cnt1..cnt5=0, all 16 table entries=0, and settle counter=0.
REQ-029 rst asserted mid-sweep SHALL discard the sweep, with no done pulse.
REQ-030 After rst deasserts, the block SHALL wait for a new start.

Verification
REQ-031 SETTLE_CYCLES=1, start pulse -> done exactly 33 cycles later; cnt1=6, cnt2=9, cnt3=8, cnt4=8, cnt5=6.
REQ-032 After a full sweep -> rd_addr=0 gives rd_data=5'b10010; rd_addr=10 gives 5'b11101; rd_addr=15 gives 5'b00100.
REQ-033 SETTLE_CYCLES=3 -> each abcd value is held 4 cycles and done arrives 65 cycles after start; busy is high for 64 cycles.
REQ-034 abort while abcd=5 in DRIVE -> IDLE next cycle, aborted=1, no done pulse, table[0..4] valid, table[5..15]=0 (first sweep after reset).
REQ-035 rst pulse while abcd=9 -> all outputs, counts and table read 0 within the same cycle; a subsequent start gives a normal sweep.
REQ-036 start pulsed while busy -> ignored; start held high continuously -> back-to-back sweeps with one IDLE cycle between done and the next abcd=0.
